// File: rtl/id_stage_if.sv
// IF/ID and ID/EX pipeline-boundary bundles for the decode stage.

// IF/ID boundary: upstream presents an instruction, decode answers with in_ready.
interface ifid_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;

  modport master (output in_valid, in_instr, in_pc, input in_ready);
  modport slave  (input in_valid, in_instr, in_pc, output in_ready);
endinterface

// ID/EX boundary: registered decode results consumed by the execute stage.
interface idex_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_imm;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_op;
  logic [1:0]      ex_a_sel;
  logic            ex_b_sel;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rd, ex_imm, ex_funct3, ex_alu_op, ex_a_sel,
           ex_b_sel, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch,
           ex_jump, ex_illegal
  );
  modport slave (
    input ex_valid, ex_pc, ex_rd, ex_imm, ex_funct3, ex_alu_op, ex_a_sel,
          ex_b_sel, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch,
          ex_jump, ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, load-use stall/bubble, EX flush,
// and the ID/EX pipeline register aligned with the register-file read.
module id_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ifid_if.slave                 ifid,
  input  logic                  ex_flush,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  idex_if.master                idex,
  output logic [PERF_WIDTH-1:0] bubble_count
);

  localparam int unsigned RW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0]     instr;
  logic [RW-1:0]   rd_d;
  logic [2:0]      funct3_d;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] imm_d;
  logic [3:0]      alu_op_d;
  logic [1:0]      a_sel_d;
  logic            b_sel_d;
  logic            mem_read_d, mem_write_d, writes_rd_d, reg_write_d;
  logic            branch_d, jump_d, illegal_d;
  logic            use_rs1, use_rs2;
  logic            hazard;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q;
  logic [RW-1:0]   ex_rd_q;
  logic [XLEN-1:0] ex_imm_q;
  logic [2:0]      ex_funct3_q;
  logic [3:0]      ex_alu_op_q;
  logic [1:0]      ex_a_sel_q;
  logic            ex_b_sel_q;
  logic            ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;
  logic            ex_branch_q, ex_jump_q, ex_illegal_q;
  logic [PERF_WIDTH-1:0] bubble_q;

  assign instr    = ifid.in_instr;
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd_d     = instr[11:7];
  assign funct3_d = instr[14:12];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // Opcode decode into EX control, immediate selection and source-register usage.
  always_comb begin
    imm_d       = '0;
    alu_op_d    = 4'b0000;
    a_sel_d     = 2'b00;
    b_sel_d     = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    writes_rd_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    illegal_d   = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        imm_d = imm_u; a_sel_d = 2'b10; b_sel_d = 1'b1; writes_rd_d = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d = imm_u; a_sel_d = 2'b01; b_sel_d = 1'b1; writes_rd_d = 1'b1;
      end
      OPC_JAL: begin
        imm_d = imm_j; a_sel_d = 2'b01; jump_d = 1'b1; writes_rd_d = 1'b1;
      end
      OPC_JALR: begin
        imm_d = imm_i; b_sel_d = 1'b1; jump_d = 1'b1; writes_rd_d = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d = imm_b; branch_d = 1'b1; alu_op_d = 4'b1000;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        imm_d = imm_i; b_sel_d = 1'b1; mem_read_d = 1'b1; writes_rd_d = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm_d = imm_s; b_sel_d = 1'b1; mem_write_d = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        imm_d = imm_i; b_sel_d = 1'b1; writes_rd_d = 1'b1;
        alu_op_d = {(funct3_d == 3'b101) ? instr[30] : 1'b0, funct3_d};
        use_rs1 = 1'b1;
      end
      OPC_OP: begin
        writes_rd_d = 1'b1; alu_op_d = {instr[30], funct3_d};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // x0 is never written, so drop reg_write for rd=0 here rather than in WB.
  assign reg_write_d = writes_rd_d & (rd_d != '0);

  // Load in EX whose rd feeds this instruction: data isn't available until after one bubble.
  assign hazard = ifid.in_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                  ((use_rs1 & (ex_rd_q == rs1)) | (use_rs2 & (ex_rd_q == rs2)));

  // A flush discards the stalled instruction upstream too, so the stall is released.
  assign ifid.in_ready = ex_flush | ~hazard;

  // ID/EX pipeline register: reset > flush > load-use bubble > normal issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rd_q        <= '0;
      ex_imm_q       <= '0;
      ex_funct3_q    <= '0;
      ex_alu_op_q    <= '0;
      ex_a_sel_q     <= '0;
      ex_b_sel_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_jump_q      <= 1'b0;
      ex_illegal_q   <= 1'b0;
      bubble_q       <= '0;
    end else if (ex_flush || hazard) begin
      ex_valid_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_jump_q      <= 1'b0;
      ex_illegal_q   <= 1'b0;
      if (!ex_flush && (bubble_q != '1)) begin
        bubble_q <= bubble_q + PERF_WIDTH'(1);
      end
    end else begin
      ex_valid_q     <= ifid.in_valid;
      ex_pc_q        <= ifid.in_pc;
      ex_rd_q        <= rd_d;
      ex_imm_q       <= imm_d;
      ex_funct3_q    <= funct3_d;
      ex_alu_op_q    <= alu_op_d;
      ex_a_sel_q     <= a_sel_d;
      ex_b_sel_q     <= b_sel_d;
      ex_mem_read_q  <= ifid.in_valid & mem_read_d;
      ex_mem_write_q <= ifid.in_valid & mem_write_d;
      ex_reg_write_q <= ifid.in_valid & reg_write_d;
      ex_branch_q    <= ifid.in_valid & branch_d;
      ex_jump_q      <= ifid.in_valid & jump_d;
      ex_illegal_q   <= ifid.in_valid & illegal_d;
    end
  end

  assign idex.ex_valid     = ex_valid_q;
  assign idex.ex_pc        = ex_pc_q;
  assign idex.ex_rd        = ex_rd_q;
  assign idex.ex_imm       = ex_imm_q;
  assign idex.ex_funct3    = ex_funct3_q;
  assign idex.ex_alu_op    = ex_alu_op_q;
  assign idex.ex_a_sel     = ex_a_sel_q;
  assign idex.ex_b_sel     = ex_b_sel_q;
  assign idex.ex_mem_read  = ex_mem_read_q;
  assign idex.ex_mem_write = ex_mem_write_q;
  assign idex.ex_reg_write = ex_reg_write_q;
  assign idex.ex_branch    = ex_branch_q;
  assign idex.ex_jump      = ex_jump_q;
  assign idex.ex_illegal   = ex_illegal_q;
  assign bubble_count      = bubble_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scoreboard of expected ID/EX contents.
module tb_id_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 16;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rd;
    logic [31:0]   imm;
    logic [2:0]    funct3;
    logic [3:0]    alu;
    logic [1:0]    a_sel;
    logic          b_sel;
    logic          mr;
    logic          mw;
    logic          rw;
    logic          br;
    logic          jp;
    logic          ill;
    logic [PW-1:0] bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ex_flush;
  logic [4:0] rs1, rs2;
  logic [PW-1:0] bubble_count;

  ifid_if #(.XLEN(XLEN)) ifid ();
  idex_if #(.XLEN(XLEN)) idex ();

  id_stage #(.XLEN(XLEN), .PERF_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid         (ifid.slave),
    .ex_flush     (ex_flush),
    .rs1          (rs1),
    .rs2          (rs2),
    .idex         (idex.master),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t e, got, want;
  logic rdy_obs;
  logic [PW-1:0] exp_bc;
  logic [31:0] pc_cnt = 32'h100;

  // Data fields are don't-care for empty or illegal slots.
  function automatic exp_t mask(input exp_t x);
    exp_t m = x;
    if (!m.valid || m.ill) begin
      m.rd = '0; m.imm = '0; m.funct3 = '0; m.alu = '0; m.a_sel = '0; m.b_sel = '0;
    end
    return m;
  endfunction

  function automatic exp_t snap();
    exp_t s;
    s.valid  = idex.ex_valid;    s.rd    = idex.ex_rd;     s.imm   = idex.ex_imm;
    s.funct3 = idex.ex_funct3;   s.alu   = idex.ex_alu_op; s.a_sel = idex.ex_a_sel;
    s.b_sel  = idex.ex_b_sel;    s.mr    = idex.ex_mem_read;
    s.mw     = idex.ex_mem_write; s.rw   = idex.ex_reg_write;
    s.br     = idex.ex_branch;   s.jp    = idex.ex_jump;   s.ill   = idex.ex_illegal;
    s.bc     = bubble_count;
    return s;
  endfunction

  // Drive one IF/ID slot at negedge, record in_ready, and queue the expected EX state.
  task automatic issue(input logic v, input logic [31:0] instr, input logic fl, input exp_t x);
    @(negedge clk);
    ifid.in_valid = v;
    ifid.in_instr = instr;
    ifid.in_pc    = pc_cnt;
    ex_flush      = fl;
    pc_cnt        = pc_cnt + 32'd4;
    #1;
    rdy_obs = ifid.in_ready;
    sb.push_back(x);
  endtask

  task automatic next_out();
    @(posedge clk);
    #1;
    got  = mask(snap());
    want = mask(sb.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_flush = 1'b0;
    ifid.in_valid = 1'b1; ifid.in_instr = 32'h00500093; ifid.in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    want = '0;
    got  = snap();
    checks++;
    if (got !== want) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", got, want);
    end
    checks++;
    if (ifid.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", ifid.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_bc = '0;
  endtask

  task automatic test_addi();
    e = '0; e.valid = 1; e.rd = 5'd1; e.imm = 32'd5; e.b_sel = 1; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h00500093, 1'b0, e);
    checks++;
    if ({rs1, rs2} !== {5'd0, 5'd5}) begin
      failures++; $display("FAIL addi_rs got=%h exp=%h", {rs1, rs2}, {5'd0, 5'd5});
    end
    checks++;
    if (rdy_obs !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b exp=1", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL addi_ex got=%h exp=%h", got, want); end
  endtask

  task automatic test_load_use();
    e = '0; e.valid = 1; e.rd = 5'd2; e.funct3 = 3'd2; e.b_sel = 1; e.mr = 1; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h0000A103, 1'b0, e);
    checks++;
    if (rdy_obs !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL lw_ex got=%h exp=%h", got, want); end
    // Dependent add stalls for one bubble.
    exp_bc = exp_bc + PW'(1);
    e = '0; e.bc = exp_bc;
    issue(1'b1, 32'h002101B3, 1'b0, e);
    checks++;
    if ({rs1, rs2} !== {5'd2, 5'd2}) begin
      failures++; $display("FAIL add_rs got=%h exp=%h", {rs1, rs2}, {5'd2, 5'd2});
    end
    checks++;
    if (rdy_obs !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL bubble_ex got=%h exp=%h", got, want); end
    e = '0; e.valid = 1; e.rd = 5'd3; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h002101B3, 1'b0, e);
    checks++;
    if (rdy_obs !== 1'b1) begin failures++; $display("FAIL post_stall_ready got=%b exp=1", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL add_ex got=%h exp=%h", got, want); end
  endtask

  task automatic test_branch();
    e = '0; e.valid = 1; e.rd = 5'd25; e.imm = 32'hFFFFFFF8; e.alu = 4'b1000; e.br = 1; e.bc = exp_bc;
    issue(1'b1, 32'hFE000CE3, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL beq_ex got=%h exp=%h", got, want); end
  endtask

  task automatic test_flush_hazard();
    e = '0; e.valid = 1; e.rd = 5'd2; e.funct3 = 3'd2; e.b_sel = 1; e.mr = 1; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h0000A103, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL lw2_ex got=%h exp=%h", got, want); end
    e = '0; e.bc = exp_bc;
    issue(1'b1, 32'h002101B3, 1'b1, e);
    checks++;
    if (rdy_obs !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL flush_ex got=%h exp=%h", got, want); end
    e = '0; e.valid = 1; e.rd = 5'd3; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h002101B3, 1'b0, e);
    checks++;
    if (rdy_obs !== 1'b1) begin failures++; $display("FAIL refetch_ready got=%b exp=1", rdy_obs); end
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL refetch_ex got=%h exp=%h", got, want); end
  endtask

  task automatic test_decode_misc();
    e = '0; e.valid = 1; e.ill = 1; e.bc = exp_bc;
    issue(1'b1, 32'h0000007F, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL illegal_ex got=%h exp=%h", got, want); end
    e = '0; e.valid = 1; e.rd = 5'd5; e.alu = 4'b1000; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h407302B3, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL sub_ex got=%h exp=%h", got, want); end
    // lui x0 must not write the register file.
    e = '0; e.valid = 1; e.rd = 5'd0; e.imm = 32'h12345000; e.funct3 = 3'd5;
    e.a_sel = 2'b10; e.b_sel = 1; e.rw = 0; e.bc = exp_bc;
    issue(1'b1, 32'h12345037, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL lui_x0_ex got=%h exp=%h", got, want); end
    e = '0; e.valid = 1; e.rd = 5'd1; e.imm = 32'd8; e.a_sel = 2'b01; e.jp = 1; e.rw = 1; e.bc = exp_bc;
    issue(1'b1, 32'h008000EF, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL jal_ex got=%h exp=%h", got, want); end
    e = '0; e.bc = exp_bc;
    issue(1'b0, 32'h0000A103, 1'b0, e);
    next_out();
    checks++;
    if (got !== want) begin failures++; $display("FAIL idle_ex got=%h exp=%h", got, want); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_branch();
    test_flush_hazard();
    test_decode_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
